dram_fifo: RTL and testbench

Synchronous single-clock FIFO built on one `dram` instance: writes go through the instance's write port (port 1), and the head entry is read through its asynchronous read port (port 0). The FIFO uses a first-word-fall-through push/pop handshake. It sits between producer and consumer blocks that need rate decoupling without a block-RAM read cycle, such as command queues and response buffers.

---
 rtl/dram_fifo_if.sv | 39 +++
 rtl/dram_fifo.sv | 112 +++++++++++
 tb/tb_dram_fifo.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dram_fifo_if.sv
// dram_fifo_if: push/pop handshake bundle for dram_fifo.
// The slave modport is the FIFO side and the master modport is the producer/consumer side.
interface dram_fifo_if #(
  parameter int SZ = 8,
  parameter int DW = 32
);
  localparam int AW = $clog2(SZ);

  logic          clear_i;
  logic          push_i;
  logic [DW-1:0] data_i;
  logic          full_o;
  logic          pop_i;
  logic [DW-1:0] data_o;
  logic          empty_o;
  logic [AW:0]   usage_o;

  modport slave (
    input  clear_i,
    input  push_i,
    input  data_i,
    input  pop_i,
    output full_o,
    output data_o,
    output empty_o,
    output usage_o
  );

  modport master (
    output clear_i,
    output push_i,
    output data_i,
    output pop_i,
    input  full_o,
    input  data_o,
    input  empty_o,
    input  usage_o
  );
endinterface

// File: rtl/dram_fifo.sv
// dram_fifo: first-word-fall-through FIFO built on a distributed RAM.
// The RAM has one synchronous write port and one asynchronous read port.
// Define DRAM_FIFO_OREG_EN to register data_o. The registered path prefetches the head
// for the next cycle and includes a write bypass, so cycle behaviour matches the
// combinational path.

// dram: distributed RAM with an asynchronous read port (port 0) and a clocked write port (port 1).
module dram #(
  parameter int SZ = 8,
  parameter int DW = 32,
  localparam int AW = $clog2(SZ)
) (
  input  logic          clk,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic [AW-1:0] raddr0,
  output logic [DW-1:0] rdata0
);
  logic [DW-1:0] mem [SZ];

  // Write port: contents are never reset, only overwritten by accepted pushes.
  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
endmodule

module dram_fifo #(
  parameter int SZ = 8,
  parameter int DW = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  dram_fifo_if.slave bus
);
  localparam int AW = $clog2(SZ);
  localparam int PW = AW + 1;

  logic [PW-1:0] wp, rp, wp_next, rp_next;
  logic          empty, full;
  logic          push_ok, pop_ok, ram_we;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  // The extra MSB on each pointer separates the full case from the empty case when the low bits match.
  assign empty   = (wp == rp);
  assign full    = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign push_ok = bus.push_i & ~full;
  assign pop_ok  = bus.pop_i & ~empty;
  assign ram_we  = push_ok & ~bus.clear_i;

  assign bus.empty_o = empty;
  assign bus.full_o  = full;
  assign bus.usage_o = wp - rp;

  // Next pointer values: clear wins; otherwise each pointer advances on its accepted request.
  always_comb begin
    wp_next = wp;
    rp_next = rp;
    if (bus.clear_i) begin
      wp_next = '0;
      rp_next = '0;
    end else begin
      if (push_ok) wp_next = wp + PW'(1);
      if (pop_ok)  rp_next = rp + PW'(1);
    end
  end

  // Pointer registers, cleared asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp_next;
      rp <= rp_next;
    end
  end

  dram #(.SZ(SZ), .DW(DW)) u_dram (
    .clk    (clk_i),
    .we1    (ram_we),
    .waddr1 (wp[AW-1:0]),
    .wdata1 (bus.data_i),
    .raddr0 (ram_raddr),
    .rdata0 (ram_rdata)
  );

`ifdef DRAM_FIFO_OREG_EN
  logic [DW-1:0] data_q;

  // The registered path reads ahead at the post-pop read pointer.
  assign ram_raddr = rp_next[AW-1:0];

  // Output register: load the next head. Bypass when this edge writes that same slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (!bus.clear_i) begin
      if (ram_we && (wp[AW-1:0] == rp_next[AW-1:0])) data_q <= bus.data_i;
      else                                           data_q <= ram_rdata;
    end
  end

  assign bus.data_o = data_q;
`else
  assign ram_raddr  = rp[AW-1:0];
  assign bus.data_o = ram_rdata;
`endif
endmodule

// File: tb/tb_dram_fifo.sv
// tb_dram_fifo: directed and randomized checks of dram_fifo against a queue reference model.
module tb_dram_fifo;
  localparam int SZ = 8;
  localparam int DW = 32;

  logic clk_i;
  logic rst_ni;
  int   test_count = 0;
  int   fail_count = 0;
  logic [DW-1:0] q [$];

  dram_fifo_if #(.SZ(SZ), .DW(DW)) bus ();

  dram_fifo #(.SZ(SZ), .DW(DW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference behaviour for one clock edge. Both requests are judged against the occupancy before the edge.
  task automatic model_edge(input bit push, input bit pop, input bit clear, input logic [DW-1:0] d);
    bit pop_ok;
    bit push_ok;
    pop_ok  = pop && (q.size() > 0);
    push_ok = push && (q.size() < SZ);
    if (clear) q.delete();
    else begin
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(d);
    end
  endtask

  // Drive one cycle of requests, let the edge happen, update the model, then settle 1 time unit past the edge.
  task automatic applyStimulus(input bit push, input bit pop, input bit clear, input logic [DW-1:0] d);
    bus.push_i  = push;
    bus.pop_i   = pop;
    bus.clear_i = clear;
    bus.data_i  = d;
    @(posedge clk_i);
    model_edge(push, pop, clear, d);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    test_count++;
    assert (got === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic checkOutput(input string tag);
    int n;
    n = q.size();
    test_count++;
    assert (bus.empty_o === (n == 0)) else begin
      fail_count++;
      $error("[TB] FAIL %s empty_o: got %b expected %b", tag, bus.empty_o, (n == 0));
    end
    test_count++;
    assert (bus.full_o === (n == SZ)) else begin
      fail_count++;
      $error("[TB] FAIL %s full_o: got %b expected %b", tag, bus.full_o, (n == SZ));
    end
    test_count++;
    assert (bus.usage_o === 4'(n)) else begin
      fail_count++;
      $error("[TB] FAIL %s usage_o: got %0d expected %0d", tag, bus.usage_o, n);
    end
    if (n != 0) begin
      test_count++;
      assert (bus.data_o === q[0]) else begin
        fail_count++;
        $error("[TB] FAIL %s data_o: got %h expected %h", tag, bus.data_o, q[0]);
      end
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    bus.push_i  = 1'b0;
    bus.pop_i   = 1'b0;
    bus.clear_i = 1'b0;
    bus.data_i  = '0;

    // Reset, then idle.
    @(posedge clk_i);
    #1;
    checkOutput("reset");
`ifdef DRAM_FIFO_OREG_EN
    checkValue("reset_data", bus.data_o, 32'h0);
`endif
    rst_ni = 1'b1;
    applyStimulus(0, 0, 0, '0);
    checkOutput("idle");

    // Fill with 0xA0..0xA7, try one more push, then drain.
    for (int i = 0; i < SZ; i++) begin
      applyStimulus(1, 0, 0, 32'hA0 + 32'(i));
      checkOutput("fill");
    end
    checkValue("fill_full", 32'(bus.full_o), 32'd1);
    checkValue("fill_usage", 32'(bus.usage_o), 32'd8);
    applyStimulus(1, 0, 0, 32'hFF);
    checkValue("drop_usage", 32'(bus.usage_o), 32'd8);
    for (int i = 0; i < SZ; i++) begin
      checkValue("drain_head", bus.data_o, 32'hA0 + 32'(i));
      applyStimulus(0, 1, 0, '0);
      checkOutput("drain");
    end
    checkValue("drain_empty", 32'(bus.empty_o), 32'd1);

    // Push into an empty FIFO while pop is held high.
    applyStimulus(1, 1, 0, 32'h11);
    checkOutput("fwft_push");
    checkValue("fwft_data", bus.data_o, 32'h11);
    applyStimulus(0, 1, 0, '0);
    checkOutput("fwft_pop");
    checkValue("fwft_empty", 32'(bus.empty_o), 32'd1);

    // Four entries held, then streaming push+pop that wraps both pointers.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, $urandom);
      checkOutput("pre4");
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 0, 32'h100 + 32'(i));
      checkOutput("stream");
      checkValue("stream_usage", 32'(bus.usage_o), 32'd4);
    end

    // Fill, then push and pop in the same cycle while full.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, $urandom);
      checkOutput("refill");
    end
    applyStimulus(1, 1, 0, 32'h55);
    checkOutput("full_pushpop");
    checkValue("full_pushpop_usage", 32'(bus.usage_o), 32'd7);
    checkValue("full_pushpop_full", 32'(bus.full_o), 32'd0);

    // Trim to five entries, then clear together with a push.
    applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 1, 0, '0);
    checkOutput("five");
    applyStimulus(1, 0, 1, 32'h77);
    checkOutput("clear");
    checkValue("clear_usage", 32'(bus.usage_o), 32'd0);

    // Refill a little, then apply an asynchronous reset away from any clock edge.
    applyStimulus(1, 0, 0, 32'h123);
    applyStimulus(1, 0, 0, 32'h456);
    checkOutput("pre_rst");
    bus.push_i = 1'b1;
    bus.data_i = 32'h999;
    #2;
    rst_ni = 1'b0;
    q.delete();
    #1;
    checkOutput("async_rst");
    checkValue("async_rst_empty", 32'(bus.empty_o), 32'd1);
`ifdef DRAM_FIFO_OREG_EN
    checkValue("async_rst_data", bus.data_o, 32'h0);
`endif
    bus.push_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("in_rst");
    rst_ni = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
                    ($urandom_range(0, 39) == 0), $urandom);
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
